// File: rtl/candy_pkg.sv
// Shared types and constants for the candy RV32I core.
package candy_pkg;

    localparam int XLEN = 32;
    localparam int INS_W = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [INS_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [INS_W-1:0] ins;
    } fetch_t;

endpackage

// File: rtl/candy_fetch_fifo.sv
// Two-entry queue of fetched {pc, ins}; entry e0 is always the head.
module candy_fetch_fifo
    import candy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_t     din,
    output fetch_t     head,
    output logic [1:0] count
);

    fetch_t e0;
    fetch_t e1;

    assign head = e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves while the new word joins behind it.
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/candy_fetch.sv
// Fetch stage: owns the PC, reads the sync ROM, buffers words for decode.
module candy_fetch
    import candy_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ROM_AW   = 12
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              imem_req,
    output logic [ROM_AW-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ins,
    output logic [31:0]       out_pc
);

    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        run;
    logic        inflight;
    logic        tag;
    logic        epoch;
    logic [1:0]  count;
    logic [2:0]  occ;
    logic        pop;
    logic        push;
    logic        issue;
    fetch_t      head;
    fetch_t      din;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign out_valid = (count != 2'd0);
    assign out_ins   = head.ins;
    assign out_pc    = head.pc;
    assign pop       = out_valid && out_ready;

    // Slots already claimed: buffered words plus the response on its way.
    assign occ   = {1'b0, count} + {2'b00, inflight};
    assign issue = run && !redirect_valid
                && (occ < (3'd2 + {2'b00, pop}));
    assign push  = inflight && (tag == epoch) && !redirect_valid;

    assign imem_req  = issue;
    assign imem_addr = pc[ROM_AW+1:2];
    assign din       = '{pc: req_pc, ins: imem_rdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            run      <= 1'b0;
            inflight <= 1'b0;
            tag      <= 1'b0;
            epoch    <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= issue;
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
                tag    <= epoch;
            end
            if (redirect_valid) begin
                pc    <= {redirect_pc[31:2], 2'b00};
                epoch <= ~epoch;
            end
        end
    end

    candy_fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

endmodule
